paddle_motion: RTL and testbench
================================

// Module: paddle_motion
// PURPOSE
//   Converts the 2-bit move request from the paddle AI (or player input) into a registered
//   paddle Y position, stepped once per video frame.
//   Sits downstream of the AI stage; its paddle_pos output feeds back to the AI and on to
//   the renderer and collision logic.
//   Adds a speed ramp for sustained movement, screen-edge clamping and a recenter command
//   for serve.
// PARAMETERS
//   SCREEN_H      10'd480  visible field height in pixels
//   PADDLE_H      10'd50   paddle height in pixels; paddle_pos is the top edge
//   START_POS     10'd215  reset/recenter position, (SCREEN_H-PADDLE_H)/2
//   BASE_SPEED    4'd2     pixels per frame at movement start
//   MAX_SPEED     4'd6     speed ceiling
//   ACCEL_TICKS   4'd8     consecutive unclamped moves before the speed increments by 1
// PORTS
//   clk         in   1   system clock
//   reset       in   1   asynchronous, active-high reset
//   frame_tick  in   1   1-cycle pulse once per frame (end of vsync)
//   move_req    in   2   01=up, 10=down, 00/11=hold
//   recenter    in   1   synchronous 1-cycle command: snap paddle to START_POS
//   paddle_pos  out  10  registered paddle top-edge Y, range 0..SCREEN_H-PADDLE_H
//   speed       out  4   current step size (pixels/frame)
//   moving      out  1   1 while state is UP or DOWN
//   at_top      out  1   paddle_pos == 0 (decoded from the register, same cycle)
//   at_bottom   out  1   paddle_pos == SCREEN_H-PADDLE_H
// BEHAVIOUR
//   Reset (async, any time): paddle_pos=START_POS, state=IDLE, speed=BASE_SPEED, acc_cnt=0,
//     moving=0. at_top/at_bottom follow from paddle_pos.
//   FSM states: IDLE, UP, DOWN. move_req is sampled only on cycles where frame_tick=1.
//     All other cycles hold every register unchanged.
//   Priority per cycle: reset > recenter > frame_tick.
//   recenter=1 takes effect on that clock edge whether or not frame_tick=1:
//     pos=START_POS, state=IDLE, speed=BASE, acc_cnt=0. A simultaneous tick is discarded.
//   On tick with hold (00/11): state=IDLE, speed=BASE, acc_cnt=0, pos unchanged.
//   On tick with a direction different from the current state (including from IDLE):
//     - enter UP/DOWN with speed=BASE and acc_cnt=0.
//     - move by BASE_SPEED on this same tick.
//   On tick with the same direction: move by the current speed, then apply the ramp:
//     - if acc_cnt==ACCEL_TICKS-1: acc_cnt=0 and speed=min(speed+1, MAX_SPEED);
//     - else acc_cnt+=1.
//     The new speed applies from the next tick.
//   Arithmetic: 11-bit unsigned with no wrap.
//     - up:   if pos < speed then pos=0, else pos-=speed.
//     - down: if pos+speed > SCREEN_H-PADDLE_H then pos=SCREEN_H-PADDLE_H, else pos+=speed.
//   Clamp event (the limit was reached by saturation, or the paddle was already at it):
//     speed=BASE and acc_cnt=0; the state stays UP/DOWN.
//   Latency: paddle_pos changes on the clock edge that samples frame_tick=1, so the new
//     value is visible the cycle after the tick. No combinational path from the inputs
//     to paddle_pos.
//   Widths: acc_cnt is 4 bits. Parameters must satisfy BASE_SPEED <= MAX_SPEED <= 15
//     and PADDLE_H < SCREEN_H.
// TESTING
//   1 Reset asserted mid-move at pos 300 -> paddle_pos=215, speed=2, moving=0
//     immediately, without waiting for a clock edge.
//   2 move_req=10 held for 9 ticks from 215 -> after tick 8 pos=231 and speed=3;
//     after tick 9 pos=234.
//   3 move_req=10 from pos 425, speed 2 -> 427, 429, 430 (clamped), at_bottom=1, speed=2;
//     a further tick stays at 430.
//   4 Up at speed 5 from pos 12 -> 7, 2, 0; at_top=1 and speed resets to 2.
//   5 Reversal: down at speed 4, then 01 on the next tick -> pos decreases by 2,
//     speed=2, state UP.
//   6 recenter and frame_tick together while moving down from 100 -> pos=215,
//     moving=0; no step applied.
//     Ticks with move_req=11 and with 00 -> pos unchanged, moving=0.

Source files
------------

// File: rtl/paddle_motion.sv
// Paddle Y-position stepper: one move per frame tick, with a speed ramp for
// sustained movement, clamping at the screen edges, and a serve recenter.
module paddle_motion #(
  parameter logic [9:0] SCREEN_H    = 10'd480,
  parameter logic [9:0] PADDLE_H    = 10'd50,
  parameter logic [9:0] START_POS   = 10'd215,
  parameter logic [3:0] BASE_SPEED  = 4'd2,
  parameter logic [3:0] MAX_SPEED   = 4'd6,
  parameter logic [3:0] ACCEL_TICKS = 4'd8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_tick_i,
  input  logic [1:0] move_req_i,
  input  logic       recenter_i,
  output logic [9:0] paddle_pos_o,
  output logic [3:0] speed_o,
  output logic       moving_o,
  output logic       at_top_o,
  output logic       at_bottom_o
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_e;

  localparam logic [10:0] MAX_POS = {1'b0, SCREEN_H - PADDLE_H};

  state_e      state_q, state_d;
  logic [9:0]  pos_q, pos_d;
  logic [3:0]  speed_q, speed_d;
  logic [3:0]  acc_q, acc_d;

  logic        goUp, goDown, sameDir;
  logic [3:0]  stepSpeed, stepAcc;
  logic [10:0] posExt, stepExt, downSum;

  // A new direction restarts the ramp from base; continuing reuses the live speed.
  assign goUp      = (move_req_i == 2'b01);
  assign goDown    = (move_req_i == 2'b10);
  assign sameDir   = (goUp && state_q == UP) || (goDown && state_q == DOWN);
  assign stepSpeed = sameDir ? speed_q : BASE_SPEED;
  assign stepAcc   = sameDir ? acc_q : 4'd0;
  assign posExt    = {1'b0, pos_q};
  assign stepExt   = {7'd0, stepSpeed};
  assign downSum   = posExt + stepExt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pos_q   <= START_POS;
      speed_q <= BASE_SPEED;
      acc_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      speed_q <= speed_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    logic clampEv;
    state_d = state_q;
    pos_d   = pos_q;
    speed_d = speed_q;
    acc_d   = acc_q;
    clampEv = 1'b0;

    if (recenter_i) begin
      state_d = IDLE;
      pos_d   = START_POS;
      speed_d = BASE_SPEED;
      acc_d   = 4'd0;
    end else if (frame_tick_i) begin
      if (!goUp && !goDown) begin
        state_d = IDLE;
        speed_d = BASE_SPEED;
        acc_d   = 4'd0;
      end else begin
        state_d = goUp ? UP : DOWN;
        if (goUp) begin
          if (posExt < stepExt || pos_q == 10'd0) begin
            pos_d   = 10'd0;
            clampEv = 1'b1;
          end else begin
            pos_d = pos_q - {6'd0, stepSpeed};
          end
        end else begin
          if (downSum > MAX_POS || posExt == MAX_POS) begin
            pos_d   = MAX_POS[9:0];
            clampEv = 1'b1;
          end else begin
            pos_d = downSum[9:0];
          end
        end

        // Hitting an edge drops back to base speed; otherwise the move counts toward the ramp.
        if (clampEv) begin
          speed_d = BASE_SPEED;
          acc_d   = 4'd0;
        end else if (stepAcc == ACCEL_TICKS - 4'd1) begin
          acc_d   = 4'd0;
          speed_d = (stepSpeed >= MAX_SPEED) ? MAX_SPEED : stepSpeed + 4'd1;
        end else begin
          acc_d   = stepAcc + 4'd1;
          speed_d = stepSpeed;
        end
      end
    end
  end

  assign paddle_pos_o = pos_q;
  assign speed_o      = speed_q;
  assign moving_o     = (state_q != IDLE);
  assign at_top_o     = (pos_q == 10'd0);
  assign at_bottom_o  = (pos_q == MAX_POS[9:0]);

endmodule

// File: tb/tb_paddle_motion.sv
// Self-checking bench for paddle_motion: directed scenarios plus random traffic,
// compared against a frame-level model of paddle movement.
module tb_paddle_motion;

  localparam int BOTTOM = 430;
  localparam int START  = 215;
  localparam int BASE   = 2;
  localparam int TOP_SP = 6;
  localparam int RAMP   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frameTick = 1'b0;
  logic [1:0] moveReq = 2'b00;
  logic       recenter = 1'b0;
  logic [9:0] paddlePos;
  logic [3:0] speed;
  logic       moving, atTop, atBottom;

  int checks = 0;
  int failures = 0;

  // Model: position, direction (0 idle, 1 up, 2 down), speed, and how many
  // unclamped moves have happened at the current speed.
  int mPos, mDir, mSpeed, mRun;

  paddle_motion dut (
    .clk_i(clk), .reset_i(reset), .frame_tick_i(frameTick), .move_req_i(moveReq),
    .recenter_i(recenter), .paddle_pos_o(paddlePos), .speed_o(speed),
    .moving_o(moving), .at_top_o(atTop), .at_bottom_o(atBottom)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mPos = START; mDir = 0; mSpeed = BASE; mRun = 0;
  endtask

  task automatic modelStep(input logic tick, input logic [1:0] mv, input logic rec);
    int want, target;
    bit clamped;
    if (rec) begin
      modelReset();
    end else if (tick) begin
      want = (mv == 2'b01) ? 1 : (mv == 2'b10) ? 2 : 0;
      if (want == 0) begin
        mDir = 0; mSpeed = BASE; mRun = 0;
      end else begin
        if (want != mDir) begin
          mDir = want; mSpeed = BASE; mRun = 0;
        end
        target  = (want == 1) ? mPos - mSpeed : mPos + mSpeed;
        clamped = (target < 0) || (target > BOTTOM) ||
                  (want == 1 && mPos == 0) || (want == 2 && mPos == BOTTOM);
        if (clamped) begin
          mPos = (want == 1) ? 0 : BOTTOM;
          mSpeed = BASE; mRun = 0;
        end else begin
          mPos = target;
          mRun = mRun + 1;
          if (mRun == RAMP) begin
            mRun = 0;
            if (mSpeed < TOP_SP) mSpeed = mSpeed + 1;
          end
        end
      end
    end
  endtask

  task automatic checkVal(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".pos"}, int'(paddlePos), mPos);
    checkVal({tag, ".speed"}, int'(speed), mSpeed);
    checkVal({tag, ".moving"}, int'(moving), (mDir != 0) ? 1 : 0);
    checkVal({tag, ".at_top"}, int'(atTop), (mPos == 0) ? 1 : 0);
    checkVal({tag, ".at_bottom"}, int'(atBottom), (mPos == BOTTOM) ? 1 : 0);
  endtask

  // One clock cycle with the given inputs; outputs sampled 1ns after the edge.
  task automatic applyStimulus(input logic tick, input logic [1:0] mv, input logic rec);
    frameTick = tick; moveReq = mv; recenter = rec;
    modelStep(tick, mv, rec);
    @(posedge clk);
    #1;
    frameTick = 1'b0; recenter = 1'b0;
  endtask

  initial begin
    int guard;
    modelReset();
    #12;
    checkOutput("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("post_reset");

    // Sustained down from start: ramp to speed 3 after the eighth move.
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 2'b10, 1'b0);
      checkOutput($sformatf("ramp_t%0d", i));
      if (i == 8) begin
        checkVal("ramp_t8_pos_const", int'(paddlePos), 231);
        checkVal("ramp_t8_speed_const", int'(speed), 3);
      end
      if (i == 9) checkVal("ramp_t9_pos_const", int'(paddlePos), 234);
    end

    // Non-tick cycles hold everything even with a request present.
    applyStimulus(1'b0, 2'b01, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0);
    checkOutput("no_tick_hold");

    // Keep going down past 300, then reset asynchronously between edges.
    guard = 0;
    while (mPos < 300 && guard < 100) begin
      applyStimulus(1'b1, 2'b10, 1'b0);
      guard++;
    end
    checkVal("reach_300_bound", (mPos >= 300) ? 1 : 0, 1);
    checkOutput("pre_async_reset");
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async_reset");
    checkVal("async_reset_pos_const", int'(paddlePos), 215);
    @(posedge clk); #1;
    reset = 1'b0;

    // Run down into the bottom edge and push once more.
    guard = 0;
    while (mPos != BOTTOM && guard < 200) begin
      applyStimulus(1'b1, 2'b10, 1'b0);
      checkOutput("to_bottom");
      guard++;
    end
    applyStimulus(1'b1, 2'b10, 1'b0);
    checkOutput("bottom_push");
    checkVal("bottom_const", int'(paddlePos), BOTTOM);
    checkVal("bottom_speed_const", int'(speed), BASE);

    // Run up into the top edge.
    guard = 0;
    while (mPos != 0 && guard < 200) begin
      applyStimulus(1'b1, 2'b01, 1'b0);
      checkOutput("to_top");
      guard++;
    end
    applyStimulus(1'b1, 2'b01, 1'b0);
    checkOutput("top_push");
    checkVal("top_flag_const", int'(atTop), 1);

    // Build speed going down, then reverse.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 2'b10, 1'b0);
    checkOutput("pre_reverse");
    applyStimulus(1'b1, 2'b01, 1'b0);
    checkOutput("reverse");
    checkVal("reverse_speed_const", int'(speed), BASE);

    // Recenter wins over a simultaneous tick.
    applyStimulus(1'b1, 2'b10, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b1);
    checkOutput("recenter_tick");
    checkVal("recenter_pos_const", int'(paddlePos), START);

    // Hold requests.
    applyStimulus(1'b1, 2'b10, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0);
    checkOutput("hold_11");
    applyStimulus(1'b1, 2'b00, 1'b0);
    checkOutput("hold_00");

    // Random traffic with a bias toward sustained direction.
    for (int i = 0; i < 600; i++) begin
      logic t, r;
      logic [1:0] mv;
      t  = ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 39) == 0);
      mv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3))
                                       : ((i / 40) % 2 == 0 ? 2'b10 : 2'b01);
      applyStimulus(t, mv, r);
      checkOutput("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
